// File: rtl/cnn_score_serializer.sv
// Serializes one parallel CNN class-score vector into a stream of (index, score)
// beats with downstream stall, a one-cycle done pulse and a guaranteed idle gap.
`ifndef core_CO
`define core_CO 4
`endif
`ifndef ST3_OUT_BW
`define ST3_OUT_BW 8
`endif

module cnn_score_serializer #(
  parameter int CO  = `core_CO,
  parameter int BW  = `ST3_OUT_BW,
  parameter int GAP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [CO*BW-1:0]      i_scores,
  output logic                  o_ready,
  input  logic                  i_stall,
  output logic                  o_valid,
  output logic [BW-1:0]         o_cnn_value,
  output logic [$clog2(CO)-1:0] o_index_info,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int IW = $clog2(CO);
  localparam int GW = $clog2(GAP + 1);
  localparam logic [IW-1:0] K_LAST = IW'(CO - 1);
  localparam logic [GW-1:0] G_END  = GW'(GAP);

  typedef enum logic [1:0] {IDLE, SEND, GAPS} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   k_q, k_d;
  logic [GW-1:0]   g_q, g_d;
  logic [BW-1:0]   buf_q [CO];
  logic [BW-1:0]   buf_d [CO];
  logic [BW-1:0]   in_arr [CO];
  logic            valid_q, valid_d;
  logic [BW-1:0]   val_q, val_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ready_q, ready_d;

  for (genvar gi = 0; gi < CO; gi++) begin : g_unpack
    assign in_arr[gi] = i_scores[gi*BW +: BW];
  end

  // k is the index of the next score to emit; index 0 goes out on the accept edge.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    g_d     = g_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    val_d   = '0;
    idx_d   = '0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          buf_d   = in_arr;
          valid_d = 1'b1;
          val_d   = in_arr[0];
          k_d     = IW'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (!i_stall) begin
          valid_d = 1'b1;
          val_d   = buf_q[k_q];
          idx_d   = k_q;
          if (k_q == K_LAST) begin
            k_d     = '0;
            g_d     = '0;
            state_d = GAPS;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      GAPS: begin
        if (g_q == G_END) begin
          state_d = IDLE;
        end else begin
          done_d = (g_q == '0);
          g_d    = g_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      g_q     <= '0;
      buf_q   <= '{default: '0};
      valid_q <= 1'b0;
      val_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      g_q     <= g_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_valid      = valid_q;
  assign o_cnn_value  = val_q;
  assign o_index_info = idx_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_cnn_score_serializer.sv
// Bench for cnn_score_serializer: queue-based frame model checked every cycle,
// plus literal expectations for the directed frames and a downstream argmax.
module tb_cnn_score_serializer;
  localparam int CO = 4, BW = 8, GAP = 1, IW = $clog2(CO);

  logic clk = 1'b0, reset = 1'b1, i_valid = 1'b0, i_stall = 1'b0;
  logic [CO*BW-1:0] i_scores = '0;
  logic o_ready, o_valid, o_busy, o_done;
  logic [BW-1:0] o_cnn_value;
  logic [IW-1:0] o_index_info;

  int vectors = 0, miscompares = 0, cyc = 0;

  always #5 clk = ~clk;

  cnn_score_serializer #(.CO(CO), .BW(BW), .GAP(GAP)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_scores(i_scores),
    .o_ready(o_ready), .i_stall(i_stall), .o_valid(o_valid),
    .o_cnn_value(o_cnn_value), .o_index_info(o_index_info),
    .o_busy(o_busy), .o_done(o_done)
  );

  // Model: a frame is a queue of pending scores, followed by GAP idle-busy cycles.
  logic [BW-1:0] q [$];
  int gap_rem = 0;
  bit started = 0;
  logic m_valid = 0, m_ready = 0, m_busy = 0, m_done = 0;
  logic [BW-1:0] m_val = '0;
  logic [IW-1:0] m_idx = '0;

  always @(posedge clk) begin
    cyc++;
    m_valid = 0; m_val = '0; m_idx = '0; m_done = 0;
    if (reset) begin
      q.delete(); gap_rem = 0; m_ready = 1; m_busy = 0; started = 1;
    end else if (q.size() > 0) begin
      m_busy = 1; m_ready = 0;
      if (!i_stall) begin
        m_idx = IW'(CO - q.size());
        m_val = q.pop_front();
        m_valid = 1;
        if (q.size() == 0) gap_rem = GAP;
      end
    end else if (gap_rem > 0) begin
      m_done = (gap_rem == GAP);
      gap_rem--;
      m_busy = 1; m_ready = 0;
    end else if (m_ready && i_valid) begin
      for (int k = 0; k < CO; k++) q.push_back(i_scores[k*BW +: BW]);
      m_idx = '0;
      m_val = q.pop_front();
      m_valid = 1; m_busy = 1; m_ready = 0;
    end else begin
      m_ready = 1; m_busy = 0;
    end
  end

  logic log_v [4096], log_b [4096], log_d [4096], log_r [4096];
  logic [BW-1:0] log_val [4096];
  logic [IW-1:0] log_idx [4096];
  int am_q [$];
  int amax = 0, aidx = 0, low_run = 0;
  bit seen_last = 0;

  always @(negedge clk) begin
    if (cyc < 4096) begin
      log_v[cyc] = o_valid; log_b[cyc] = o_busy; log_d[cyc] = o_done;
      log_r[cyc] = o_ready; log_val[cyc] = o_cnn_value; log_idx[cyc] = o_index_info;
    end
    if (started) begin
      vectors++;
      if ({o_valid, o_cnn_value, o_index_info, o_busy, o_done, o_ready} !==
          {m_valid, m_val, m_idx, m_busy, m_done, m_ready}) begin
        miscompares++;
        $display("FAIL cycle %0d: dut v=%b val=%0d idx=%0d busy=%b done=%b rdy=%b, model v=%b val=%0d idx=%0d busy=%b done=%b rdy=%b",
                 cyc, o_valid, $signed(o_cnn_value), o_index_info, o_busy, o_done, o_ready,
                 m_valid, $signed(m_val), m_idx, m_busy, m_done, m_ready);
      end
      if (reset) seen_last = 0;
      if (o_valid) begin
        $display("cycle %0d emit idx=%0d val=%0d", cyc, o_index_info, $signed(o_cnn_value));
        if (o_index_info == 0) begin
          if (seen_last) begin
            vectors++;
            if (low_run < GAP) begin
              miscompares++;
              $display("FAIL frame_gap: got %0d idle cycles, need >= %0d", low_run, GAP);
            end
          end
          amax = $signed(o_cnn_value); aidx = 0;
        end else if ($signed(o_cnn_value) > amax) begin
          amax = $signed(o_cnn_value); aidx = int'(o_index_info);
        end
        seen_last = (o_index_info == IW'(CO - 1));
        low_run = 0;
      end else begin
        low_run++;
      end
      if (o_done) begin
        $display("cycle %0d frame done argmax=%0d", cyc, aidx);
        am_q.push_back(aidx);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [CO*BW-1:0] s, output int a0);
    i_valid = 1; i_scores = s; a0 = cyc + 1;
    tick(1);
    i_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(o_ready && !o_busy) && n < 50) begin tick(1); n++; end
    chk("idle_timeout", int'(o_ready && !o_busy), 1);
    tick(2);
  endtask

  task automatic chk_beat(input string name, input int c, input int v, input int idx, input int val);
    chk({name, "_v"}, int'(log_v[c]), v);
    chk({name, "_idx"}, int'(log_idx[c]), idx);
    chk({name, "_val"}, int'($signed(log_val[c])), val);
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, r, x;
    reset = 1; tick(3); reset = 0; tick(1);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);

    // Basic frame.
    send_frame(pack4(5, -3, 12, 7), a0);
    wait_idle();
    chk_beat("f1_b0", a0, 1, 0, 5);
    chk_beat("f1_b1", a0 + 1, 1, 1, -3);
    chk_beat("f1_b2", a0 + 2, 1, 2, 12);
    chk_beat("f1_b3", a0 + 3, 1, 3, 7);
    chk("f1_done", int'(log_d[a0 + 4]), 1);
    chk_beat("f1_gap", a0 + 4, 0, 0, 0);
    chk("f1_rdy_gap", int'(log_r[a0 + 4]), 0);
    chk("f1_rdy", int'(log_r[a0 + 5]), 1);

    // Stall over the two edges where index 2 is due.
    send_frame(pack4(5, -3, 12, 7), a0);
    tick(1); i_stall = 1; tick(2); i_stall = 0;
    wait_idle();
    chk_beat("st_b1", a0 + 1, 1, 1, -3);
    chk_beat("st_h0", a0 + 2, 0, 0, 0);
    chk_beat("st_h1", a0 + 3, 0, 0, 0);
    chk_beat("st_b2", a0 + 4, 1, 2, 12);
    chk_beat("st_b3", a0 + 5, 1, 3, 7);
    chk("st_done", int'(log_d[a0 + 6]), 1);

    // i_valid held with a new vector every cycle.
    for (int i = 0; i < 24; i++) begin
      i_valid = 1; i_scores = $urandom; tick(1);
    end
    i_valid = 0;
    wait_idle();

    // Reset while index 1 is on the output.
    send_frame(pack4(20, 21, 22, 23), a0);
    tick(1); reset = 1; tick(1); reset = 0; tick(4);
    chk_beat("ra", a0 + 2, 0, 0, 0);
    chk("ra_busy", int'(log_b[a0 + 2]), 0);
    chk("ra_nodone", int'(log_d[a0 + 2] | log_d[a0 + 3] | log_d[a0 + 4] | log_d[a0 + 5]), 0);

    // Reset beats i_valid in the same cycle.
    reset = 1; i_valid = 1; i_scores = pack4(1, 2, 3, 4); r = cyc + 1;
    tick(1); reset = 0; i_valid = 0; tick(3);
    chk("rp_valid", int'(log_v[r] | log_v[r + 1]), 0);
    chk("rp_busy", int'(log_b[r] | log_b[r + 1]), 0);

    send_frame(pack4(-128, 127, 0, -1), a0);
    wait_idle();
    chk_beat("fr_b0", a0, 1, 0, -128);
    chk_beat("fr_b1", a0 + 1, 1, 1, 127);
    chk_beat("fr_b3", a0 + 3, 1, 3, -1);

    // Downstream argmax over two consecutive frames.
    am_q.delete();
    send_frame(pack4(1, 9, 2, 3), a0);
    wait_idle();
    send_frame(pack4(8, 0, 0, 1), a0);
    wait_idle();
    chk("am_cnt", am_q.size(), 2);
    x = (am_q.size() > 0) ? am_q.pop_front() : -1;
    chk("am_f1", x, 1);
    x = (am_q.size() > 0) ? am_q.pop_front() : -1;
    chk("am_f2", x, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cnn_score_serializer.md
CNN_SCORE_SERIALIZER -- requirements
Module: cnn_score_serializer

Interface
REQ-001 SHALL have parameter CO, default `core_CO: number of class scores per frame; CO >= 2.
REQ-002 SHALL have parameter BW, default `ST3_OUT_BW: width of one signed class score.
REQ-003 SHALL have parameter GAP, default 1: idle cycles forced after the last score of a frame; GAP >= 1.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 i_valid  input  1  parallel score vector present.
REQ-007 i_scores  input  CO*BW  packed signed scores; score k = bits [k*BW +: BW].
REQ-008 o_ready  output  1  block can accept a vector this cycle.
REQ-009 i_stall  input  1  downstream hold request; pauses emission.
REQ-010 o_valid  output  1  o_cnn_value/o_index_info valid this cycle.
REQ-011 o_cnn_value  output  BW  current signed score.
REQ-012 o_index_info  output  $clog2(CO)  index of current score.
REQ-013 o_busy  output  1  frame being emitted or in gap.
REQ-014 o_done  output  1  one-cycle pulse, cycle after last score emitted.

Function
REQ-015 SHALL implement states IDLE, SEND, GAP.
REQ-016 o_ready SHALL be 1 only in IDLE; o_busy SHALL be 1 in SEND and GAP.
REQ-017 Accept SHALL occur on i_valid && o_ready; i_scores SHALL be registered in full into an internal CO*BW buffer that cycle; IDLE->SEND.
REQ-018 i_valid while o_ready=0 SHALL be ignored; the buffer SHALL NOT change outside an accept.
REQ-019 First score (index 0) SHALL appear on o_valid the cycle after accept (latency 1).
REQ-020 In SEND with i_stall=0: o_valid=1, o_cnn_value=buffer[k], o_index_info=k; k increments by 1 per cycle from 0 to CO-1.
REQ-021 In SEND with i_stall=1: o_valid=0, k SHALL hold; emission resumes at the same k when i_stall drops; no score is skipped or duplicated.
REQ-022 After emitting k=CO-1, SHALL enter GAP; k resets to 0.
REQ-023 o_done SHALL pulse 1 for exactly one cycle, the first GAP cycle.
REQ-024 GAP SHALL last exactly GAP cycles, independent of i_stall, then return to IDLE.
REQ-025 Whenever o_valid=0, o_index_info SHALL be 0 and o_cnn_value SHALL be 0 (downstream argmax never sees a stale CO-1 index while idle).
REQ-026 Consequently o_valid SHALL never be high on two consecutive frames without at least GAP low cycles between index CO-1 and the next index 0.
REQ-027 i_valid in the same cycle GAP completes SHALL NOT be accepted (o_ready still 0); accept is possible from the first IDLE cycle.
REQ-028 Index counter SHALL wrap only via REQ-022; it SHALL never exceed CO-1, including non-power-of-2 CO.
REQ-029 Scores SHALL pass through bit-exact; no arithmetic, sign extension or saturation.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, k=0, buffer=0, o_valid=0, o_cnn_value=0, o_index_info=0, o_busy=0, o_done=0, o_ready=1 from the next cycle.
REQ-032 Reset mid-SEND or mid-GAP SHALL abort the frame immediately; no o_done pulse; remaining scores are discarded.
REQ-033 Reset SHALL take priority over i_valid in the same cycle; no accept occurs.

Verification (bench CO=4, BW=8, GAP=1)
REQ-034 Accept scores {k0=5,k1=-3,k2=12,k3=7} -> o_valid cycles 1..4 after accept carrying (0,5),(1,-3),(2,12),(3,7); o_done cycle 5; o_ready=1 cycle 6.
REQ-035 Same frame, i_stall=1 during the cycle index 2 is due, for 2 cycles -> o_valid low 2 cycles, then (2,12),(3,7); total 6 cycles from first score to o_done.
REQ-036 i_valid held high continuously with new vector each cycle -> accepts only at IDLE; every frame is separated by >=1 cycle with o_valid=0 and o_index_info=0.
REQ-037 Reset asserted while index 1 is on output -> next cycle o_valid=0, o_index_info=0, o_busy=0, no o_done; a fresh vector is then accepted and emitted from index 0.
REQ-038 Back-to-back integration with the argmax comparator downstream: frames {1,9,2,3} then {8,0,0,1} -> comparator reports index 1 then index 0.
